// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, twiddle-ROM field layout and FSM states for the NTT butterfly sequencer
package ntt_pkg;

    localparam int Q  = 3329;
    localparam int CW = 12;

    // Each 64-bit ROM word carries two 32-bit butterfly ops.
    localparam int OP_W       = 32;
    localparam int OP0_LSB    = 0;
    localparam int OP1_LSB    = 32;
    // Fields inside one op.
    localparam int ZETA_LSB   = 16;
    localparam int ADDR_A_LSB = 8;
    localparam int ADDR_B_LSB = 0;
    localparam int ADDR_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD0,
        MUL0,
        WB0,
        RD1,
        MUL1,
        WB1
    } state_t;

endpackage

// File: rtl/ntt_bfly_seq_if.sv
// rtl/ntt_bfly_seq_if.sv - control, twiddle-ROM and coefficient-RAM signal bundle of the butterfly sequencer
//
// master: the sequencer (drives busy/done, ROM address, RAM strobes/addresses/write data)
// slave : the environment (drives start, ROM data, RAM read data)
interface ntt_bfly_seq_if #(
    parameter int CW = 12
);
    logic          start;
    logic          busy;
    logic          done;
    logic [6:0]    rom_addr;
    logic [63:0]   rom_data;
    logic          coef_rd_en;
    logic [7:0]    coef_rd_addr_a;
    logic [7:0]    coef_rd_addr_b;
    logic [CW-1:0] coef_rd_data_a;
    logic [CW-1:0] coef_rd_data_b;
    logic          coef_wr_en;
    logic [7:0]    coef_wr_addr_a;
    logic [7:0]    coef_wr_addr_b;
    logic [CW-1:0] coef_wr_data_a;
    logic [CW-1:0] coef_wr_data_b;

    modport master (
        input  start, rom_data, coef_rd_data_a, coef_rd_data_b,
        output busy, done, rom_addr, coef_rd_en, coef_rd_addr_a, coef_rd_addr_b,
               coef_wr_en, coef_wr_addr_a, coef_wr_addr_b, coef_wr_data_a, coef_wr_data_b
    );

    modport slave (
        output start, rom_data, coef_rd_data_a, coef_rd_data_b,
        input  busy, done, rom_addr, coef_rd_en, coef_rd_addr_a, coef_rd_addr_b,
               coef_wr_en, coef_wr_addr_a, coef_wr_addr_b, coef_wr_data_a, coef_wr_data_b
    );
endinterface

// File: rtl/ntt_modmul.sv
// rtl/ntt_modmul.sv - combinational modular multiply p = (a * b) mod Q
//
// Ports: a_i, b_i (CW bits, operands) -> p_o (CW bits, product reduced mod Q)
module ntt_modmul #(
    parameter int Q  = ntt_pkg::Q,
    parameter int CW = ntt_pkg::CW
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    output logic [CW-1:0] p_o
);
    import ntt_pkg::*;

    logic [2*CW-1:0] prod;

    always_comb begin
        prod = {{CW{1'b0}}, a_i} * {{CW{1'b0}}, b_i};
        p_o  = CW'(prod % (2*CW)'(Q));
    end
endmodule

// File: rtl/ntt_bfly_seq.sv
// rtl/ntt_bfly_seq.sv - sequencer running N_WORDS twiddle-ROM words as NTT butterflies over a coefficient RAM
//
// Ports: clk, srst (sync, active-high); bus (ntt_bfly_seq_if.master): start/busy/done,
//        rom_addr/rom_data (registered ROM), coef_rd_* (read, data one cycle after rd_en),
//        coef_wr_* (dual write, one strobe).
// Macro NTT_GS_MODE_EN: adds input inv, sampled at start; inv=1 selects the Gentleman-Sande butterfly.
module ntt_bfly_seq #(
    parameter int Q       = ntt_pkg::Q,
    parameter int N_WORDS = 128,
    parameter int CW      = ntt_pkg::CW
) (
    input  logic clk,
    input  logic srst,
`ifdef NTT_GS_MODE_EN
    input  logic inv,
`endif
    ntt_bfly_seq_if.master bus
);
    import ntt_pkg::*;

    state_t        state_q, state_d;
    logic [6:0]    k_q, k_d;
    logic [63:0]   word_q, word_d;
    logic [CW-1:0] a_q, a_d, t_q, t_d;
    logic          done_q, done_d;

    logic          start_acc, rd_act, wr_act, op1_sel;
    logic [OP_W-1:0] op_sel;
    logic [CW-1:0] zeta, mul_x, mul_p, wr_a, wr_b;
    logic          unused_zeta_hi;

    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (CW+1)'(Q)) s = s - (CW+1)'(Q);
        return s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (x < y) s = s + (CW+1)'(Q);
        return s[CW-1:0];
    endfunction

    // The ROM word is only latched at the end of RD0, so op0 reads take their
    // addresses straight from rom_data in that cycle.
    assign op1_sel = (state_q == RD1) || (state_q == MUL1) || (state_q == WB1);
    assign op_sel  = op1_sel            ? word_q[OP1_LSB +: OP_W] :
                     (state_q == RD0)   ? bus.rom_data[OP0_LSB +: OP_W] :
                                          word_q[OP0_LSB +: OP_W];
    assign zeta           = op_sel[ZETA_LSB +: CW];
    assign unused_zeta_hi = ^op_sel[OP_W-1:ZETA_LSB+CW];

`ifdef NTT_GS_MODE_EN
    logic          inv_q;
    logic [CW-1:0] b_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            inv_q <= 1'b0;
            b_q   <= '0;
        end else begin
            if (start_acc) inv_q <= inv;
            if (state_q == MUL0 || state_q == MUL1) b_q <= bus.coef_rd_data_b;
        end
    end

    assign mul_x = inv_q ? mod_sub(bus.coef_rd_data_a, bus.coef_rd_data_b) : bus.coef_rd_data_b;
    assign wr_a  = inv_q ? mod_add(a_q, b_q) : mod_add(a_q, t_q);
    assign wr_b  = inv_q ? t_q : mod_sub(a_q, t_q);
`else
    assign mul_x = bus.coef_rd_data_b;
    assign wr_a  = mod_add(a_q, t_q);
    assign wr_b  = mod_sub(a_q, t_q);
`endif

    ntt_modmul #(.Q(Q), .CW(CW)) u_modmul (
        .a_i (zeta),
        .b_i (mul_x),
        .p_o (mul_p)
    );

    // A start landing on the done cycle is dropped along with any start while busy.
    assign start_acc = (state_q == IDLE) && bus.start && !done_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        a_d     = a_q;
        t_d     = t_q;
        done_d  = 1'b0;
        rd_act  = 1'b0;
        wr_act  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = FETCH;
                    k_d     = '0;
                end
            end
            FETCH: state_d = RD0;
            RD0: begin
                word_d  = bus.rom_data;
                rd_act  = 1'b1;
                state_d = MUL0;
            end
            MUL0, MUL1: begin
                t_d     = mul_p;
                a_d     = bus.coef_rd_data_a;
                state_d = (state_q == MUL0) ? WB0 : WB1;
            end
            WB0: begin
                wr_act  = 1'b1;
                state_d = RD1;
            end
            RD1: begin
                rd_act  = 1'b1;
                state_d = MUL1;
            end
            WB1: begin
                wr_act = 1'b1;
                if (k_q == 7'(N_WORDS-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + 7'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            k_q     <= '0;
            word_q  <= '0;
            a_q     <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
            a_q     <= a_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    // Strobes are gated by srst so a reset landing on a WB cycle writes nothing.
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.rom_addr       = k_q;
    assign bus.coef_rd_en     = rd_act && !srst;
    assign bus.coef_rd_addr_a = rd_act ? op_sel[ADDR_A_LSB +: ADDR_W] : '0;
    assign bus.coef_rd_addr_b = rd_act ? op_sel[ADDR_B_LSB +: ADDR_W] : '0;
    assign bus.coef_wr_en     = wr_act && !srst;
    assign bus.coef_wr_addr_a = wr_act ? op_sel[ADDR_A_LSB +: ADDR_W] : '0;
    assign bus.coef_wr_addr_b = wr_act ? op_sel[ADDR_B_LSB +: ADDR_W] : '0;
    assign bus.coef_wr_data_a = wr_act ? wr_a : '0;
    assign bus.coef_wr_data_b = wr_act ? wr_b : '0;
endmodule
